// File: rtl/riscv_wb_arbiter.sv
// rtl/riscv_wb_arbiter.sv - register-file writeback arbiter for ALU, LSU and multicycle results
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   alu_*_i                       ALU result (always accepted)
//   lsu_*_i                       load result (always accepted)
//   mc_*_i, mc_ready_o            multicycle result, valid/ready handshake into a FIFO
//   waddr_a_o..we_a_o             registered write port A (ALU, else FIFO spill)
//   waddr_b_o..we_b_o             registered write port B (LSU, else FIFO head)
//   fifo_cnt_o                    multicycle FIFO occupancy
//   conflict_o                    registered pulse: A and B write the same address
module riscv_wb_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid_i,
    input  logic [ADDR_WIDTH-1:0]      alu_waddr_i,
    input  logic [DATA_WIDTH-1:0]      alu_wdata_i,
    input  logic                       alu_wtag_i,
    input  logic                       lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0]      lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]      lsu_wdata_i,
    input  logic                       lsu_wtag_i,
    input  logic                       mc_valid_i,
    input  logic [ADDR_WIDTH-1:0]      mc_waddr_i,
    input  logic [DATA_WIDTH-1:0]      mc_wdata_i,
    input  logic                       mc_wtag_i,
    output logic                       mc_ready_o,
    output logic [ADDR_WIDTH-1:0]      waddr_a_o,
    output logic [DATA_WIDTH-1:0]      wdata_a_o,
    output logic                       wtag_a_o,
    output logic                       we_a_o,
    output logic [ADDR_WIDTH-1:0]      waddr_b_o,
    output logic [DATA_WIDTH-1:0]      wdata_b_o,
    output logic                       wtag_b_o,
    output logic                       we_b_o,
    output logic [$clog2(DEPTH):0]     fifo_cnt_o,
    output logic                       conflict_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic                  fifo_tag  [DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic                  b_from_fifo;
    logic                  a_from_fifo;
    logic                  a_sel;
    logic                  b_sel;
    logic [ADDR_WIDTH-1:0] a_addr_nxt;
    logic [DATA_WIDTH-1:0] a_data_nxt;
    logic                  a_tag_nxt;
    logic [ADDR_WIDTH-1:0] b_addr_nxt;
    logic [DATA_WIDTH-1:0] b_data_nxt;
    logic                  b_tag_nxt;
    logic                  we_a_nxt;
    logic                  we_b_nxt;
    logic                  conflict_nxt;

    // Ready depends only on the registered count, so a full FIFO stays
    // closed even in a cycle where it is also being drained.
    assign mc_ready_o = (count < CNT_W'(DEPTH));
    assign fifo_cnt_o = count;

    always_comb begin
        push        = mc_valid_i && mc_ready_o;
        fifo_empty  = (count == '0);
        // B prefers the LSU; the FIFO head spills to A only if B did not take it.
        b_from_fifo = !lsu_valid_i && !fifo_empty;
        a_from_fifo = !alu_valid_i && !fifo_empty && !b_from_fifo;
        pop         = b_from_fifo || a_from_fifo;

        a_sel      = alu_valid_i || a_from_fifo;
        a_addr_nxt = alu_valid_i ? alu_waddr_i : fifo_addr[rd_ptr];
        a_data_nxt = alu_valid_i ? alu_wdata_i : fifo_data[rd_ptr];
        a_tag_nxt  = alu_valid_i ? alu_wtag_i  : fifo_tag[rd_ptr];

        b_sel      = lsu_valid_i || b_from_fifo;
        b_addr_nxt = lsu_valid_i ? lsu_waddr_i : fifo_addr[rd_ptr];
        b_data_nxt = lsu_valid_i ? lsu_wdata_i : fifo_data[rd_ptr];
        b_tag_nxt  = lsu_valid_i ? lsu_wtag_i  : fifo_tag[rd_ptr];

        // x0 writes are consumed but never reach the regfile.
        we_a_nxt     = a_sel && (a_addr_nxt != '0);
        we_b_nxt     = b_sel && (b_addr_nxt != '0);
        conflict_nxt = we_a_nxt && we_b_nxt && (a_addr_nxt == b_addr_nxt);
    end

    // Storage carries no reset: validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mc_waddr_i;
            fifo_data[wr_ptr] <= mc_wdata_i;
            fifo_tag[wr_ptr]  <= mc_wtag_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            waddr_a_o  <= '0;
            wdata_a_o  <= '0;
            wtag_a_o   <= 1'b0;
            we_a_o     <= 1'b0;
            waddr_b_o  <= '0;
            wdata_b_o  <= '0;
            wtag_b_o   <= 1'b0;
            we_b_o     <= 1'b0;
            conflict_o <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps to 0.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Idle ports keep their last addr/data/tag; only we drops.
            if (a_sel) begin
                waddr_a_o <= a_addr_nxt;
                wdata_a_o <= a_data_nxt;
                wtag_a_o  <= a_tag_nxt;
            end
            if (b_sel) begin
                waddr_b_o <= b_addr_nxt;
                wdata_b_o <= b_data_nxt;
                wtag_b_o  <= b_tag_nxt;
            end
            we_a_o     <= we_a_nxt;
            we_b_o     <= we_b_nxt;
            conflict_o <= conflict_nxt;
        end
    end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb/tb_riscv_wb_arbiter.sv - scoreboard testbench for riscv_wb_arbiter
module tb_riscv_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid_i = 1'b0, lsu_valid_i = 1'b0, mc_valid_i = 1'b0;
    logic [5:0]  alu_waddr_i = '0, lsu_waddr_i = '0, mc_waddr_i = '0;
    logic [31:0] alu_wdata_i = '0, lsu_wdata_i = '0, mc_wdata_i = '0;
    logic        alu_wtag_i = 1'b0, lsu_wtag_i = 1'b0, mc_wtag_i = 1'b0;
    logic        mc_ready_o;
    logic [5:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o;
    logic        wtag_a_o, wtag_b_o, we_a_o, we_b_o, conflict_o;
    logic [2:0]  fifo_cnt_o;

    riscv_wb_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i), .alu_wtag_i(alu_wtag_i),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_wtag_i(lsu_wtag_i),
        .mc_valid_i(mc_valid_i), .mc_waddr_i(mc_waddr_i), .mc_wdata_i(mc_wdata_i), .mc_wtag_i(mc_wtag_i),
        .mc_ready_o(mc_ready_o),
        .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .wtag_a_o(wtag_a_o), .we_a_o(we_a_o),
        .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .wtag_b_o(wtag_b_o), .we_b_o(we_b_o),
        .fifo_cnt_o(fifo_cnt_o), .conflict_o(conflict_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          wa;
        logic [5:0]  aa;
        logic [31:0] ad;
        bit          at;
        bit          wb;
        logic [5:0]  ba;
        logic [31:0] bd;
        bit          bt;
        bit          conf;
        int          cnt;
        bit          rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: pops every expectation due at this cycle and compares outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("due_cycle", 64'(cyc), 64'(e.due));
            chk("we_a", 64'(we_a_o), 64'(e.wa));
            if (e.wa) begin
                chk("waddr_a", 64'(waddr_a_o), 64'(e.aa));
                chk("wdata_a", 64'(wdata_a_o), 64'(e.ad));
                chk("wtag_a", 64'(wtag_a_o), 64'(e.at));
            end
            chk("we_b", 64'(we_b_o), 64'(e.wb));
            if (e.wb) begin
                chk("waddr_b", 64'(waddr_b_o), 64'(e.ba));
                chk("wdata_b", 64'(wdata_b_o), 64'(e.bd));
                chk("wtag_b", 64'(wtag_b_o), 64'(e.bt));
            end
            chk("conflict", 64'(conflict_o), 64'(e.conf));
            chk("fifo_cnt", 64'(fifo_cnt_o), 64'(e.cnt));
            chk("mc_ready", 64'(mc_ready_o), 64'(e.rdy));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        mc_valid_i  = 1'b0;
        e_n.wa = 1'b0; e_n.aa = '0; e_n.ad = '0; e_n.at = 1'b0;
        e_n.wb = 1'b0; e_n.ba = '0; e_n.bd = '0; e_n.bt = 1'b0;
    endtask

    task automatic alu(input logic [5:0] a, input logic [31:0] d, input logic t);
        alu_valid_i = 1'b1; alu_waddr_i = a; alu_wdata_i = d; alu_wtag_i = t;
    endtask

    task automatic lsu(input logic [5:0] a, input logic [31:0] d, input logic t);
        lsu_valid_i = 1'b1; lsu_waddr_i = a; lsu_wdata_i = d; lsu_wtag_i = t;
    endtask

    task automatic mc(input logic [5:0] a, input logic [31:0] d, input logic t);
        mc_valid_i = 1'b1; mc_waddr_i = a; mc_wdata_i = d; mc_wtag_i = t;
    endtask

    task automatic ea(input logic [5:0] a, input logic [31:0] d, input logic t);
        e_n.wa = 1'b1; e_n.aa = a; e_n.ad = d; e_n.at = t;
    endtask

    task automatic eb(input logic [5:0] a, input logic [31:0] d, input logic t);
        e_n.wb = 1'b1; e_n.ba = a; e_n.bd = d; e_n.bt = t;
    endtask

    // Records what the outputs must show after the coming edge.
    task automatic issue(input int cnt, input bit rdy, input bit conf);
        e_n.due  = cyc + 1;
        e_n.cnt  = cnt;
        e_n.rdy  = rdy;
        e_n.conf = conf;
        exp_q.push_back(e_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we_a", 64'(we_a_o), 64'd0);
        chk("rst_we_b", 64'(we_b_o), 64'd0);
        chk("rst_waddr_a", 64'(waddr_a_o), 64'd0);
        chk("rst_wdata_b", 64'(wdata_b_o), 64'd0);
        chk("rst_cnt", 64'(fifo_cnt_o), 64'd0);
        chk("rst_ready", 64'(mc_ready_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // ALU only
        next_cycle(); alu(6'd5, 32'hDEADBEEF, 1'b1); ea(6'd5, 32'hDEADBEEF, 1'b1); issue(0, 1, 0);

        // MC latency through empty FIFO to port B; FP f0 (addr 32) is a real write
        next_cycle(); mc(6'd33, 32'h1234, 1'b0); issue(1, 1, 0);
        next_cycle(); eb(6'd33, 32'h1234, 1'b0); issue(0, 1, 0);
        next_cycle(); mc(6'd32, 32'hF0F0, 1'b1); issue(1, 1, 0);
        next_cycle(); eb(6'd32, 32'hF0F0, 1'b1); issue(0, 1, 0);

        // Fill with ALU+LSU busy; a 5th mc offer while full is refused
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            alu(6'd1, 32'h100 + i, 1'b0); lsu(6'd2, 32'h200 + i, 1'b1);
            mc(6'(10 + i), 32'hA0 + i, 1'(i));
            ea(6'd1, 32'h100 + i, 1'b0); eb(6'd2, 32'h200 + i, 1'b1);
            issue(i + 1, (i < 3), 0);
        end
        next_cycle(); lsu(6'd2, 32'h300, 1'b0); mc(6'd60, 32'hBAD, 1'b1);
        eb(6'd2, 32'h300, 1'b0); ea(6'd10, 32'hA0, 1'b0); issue(3, 1, 0);
        for (int i = 1; i < 4; i++) begin
            next_cycle(); lsu(6'd2, 32'h300 + i, 1'b0);
            eb(6'd2, 32'h300 + i, 1'b0); ea(6'(10 + i), 32'hA0 + i, 1'(i)); issue(3 - i, 1, 0);
        end
        next_cycle(); issue(0, 1, 0);

        // Spill: two queued, LSU on B, head goes to A
        next_cycle(); alu(6'd3, 32'h33, 1'b0); lsu(6'd4, 32'h44, 1'b0); mc(6'd40, 32'h4000, 1'b1);
        ea(6'd3, 32'h33, 1'b0); eb(6'd4, 32'h44, 1'b0); issue(1, 1, 0);
        next_cycle(); alu(6'd3, 32'h34, 1'b0); lsu(6'd4, 32'h45, 1'b0); mc(6'd41, 32'h4100, 1'b0);
        ea(6'd3, 32'h34, 1'b0); eb(6'd4, 32'h45, 1'b0); issue(2, 1, 0);
        next_cycle(); lsu(6'd6, 32'h66, 1'b1); eb(6'd6, 32'h66, 1'b1); ea(6'd40, 32'h4000, 1'b1); issue(1, 1, 0);
        next_cycle(); eb(6'd41, 32'h4100, 1'b0); issue(0, 1, 0);

        // Push and pop in the same cycle keeps the count
        next_cycle(); mc(6'd50, 32'h5000, 1'b0); issue(1, 1, 0);
        next_cycle(); mc(6'd51, 32'h5100, 1'b1); eb(6'd50, 32'h5000, 1'b0); issue(1, 1, 0);
        next_cycle(); eb(6'd51, 32'h5100, 1'b1); issue(0, 1, 0);

        // x0 writes from ALU and from FIFO, then a same-address conflict
        next_cycle(); alu(6'd0, 32'h55, 1'b0); issue(0, 1, 0);
        next_cycle(); alu(6'd8, 32'h88, 1'b0); lsu(6'd9, 32'h99, 1'b0); mc(6'd0, 32'h77, 1'b0);
        ea(6'd8, 32'h88, 1'b0); eb(6'd9, 32'h99, 1'b0); issue(1, 1, 0);
        next_cycle(); issue(0, 1, 0);
        next_cycle(); alu(6'd7, 32'h70, 1'b0); lsu(6'd7, 32'h71, 1'b1);
        ea(6'd7, 32'h70, 1'b0); eb(6'd7, 32'h71, 1'b1); issue(0, 1, 1);
        next_cycle(); issue(0, 1, 0);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            next_cycle(); alu(6'd11, 32'hC0 + i, 1'b0); lsu(6'd12, 32'hD0 + i, 1'b0);
            mc(6'(20 + i), 32'hE0 + i, 1'b0);
            ea(6'd11, 32'hC0 + i, 1'b0); eb(6'd12, 32'hD0 + i, 1'b0); issue(i + 1, 1, 0);
        end
        next_cycle();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_we_a", 64'(we_a_o), 64'd0);
        chk("mid_rst_we_b", 64'(we_b_o), 64'd0);
        chk("mid_rst_waddr_b", 64'(waddr_b_o), 64'd0);
        chk("mid_rst_cnt", 64'(fifo_cnt_o), 64'd0);
        chk("mid_rst_ready", 64'(mc_ready_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); issue(0, 1, 0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
